// File: rtl/load_extender.sv
// load_extender: M-stage load decode, alignment/range check and W-stage data extension.
//
// Data-memory loads complete in one cycle: op and byte offset are registered at the edge and
// the registered RAM word (DM_RD) is extracted combinationally in the following cycle.
// Peripheral loads (lw only) run a req/ack bridge read and stall the pipeline until the ack
// arrives or the timeout expires.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   Instr_M       M-stage instruction (opcode in [31:26])
//   ALU_Out_M     M-stage effective address
//   Flush         kill the M-stage instruction (no W result)
//   DM_RD         data-memory read word, valid the cycle after the address
//   Dev_Req       bridge read request, held until ack or timeout
//   Dev_Addr      word-aligned bridge address, stable while Dev_Req
//   Dev_Ack       bridge completion strobe
//   Dev_RD        bridge read data, valid with Dev_Ack
//   Stall         freeze F/D/E/M while a peripheral read is pending
//   LD_EXP        combinational load address exception (AdEL)
//   Bus_Err       one-cycle pulse on bridge timeout
//   Load_Data_W   extended load data for W
//   Load_Valid_W  Load_Data_W carries a valid load result this cycle
module load_extender #(
    parameter logic [31:0] DM_LIMIT    = 32'h0000_3000,
    parameter logic [31:0] DEV_BASE    = 32'h0000_7F00,
    parameter logic [31:0] DEV_LIMIT   = 32'h0000_7F2C,
    parameter int unsigned BUS_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M,
    input  logic [31:0] ALU_Out_M,
    input  logic        Flush,
    input  logic [31:0] DM_RD,
    output logic        Dev_Req,
    output logic [31:0] Dev_Addr,
    input  logic        Dev_Ack,
    input  logic [31:0] Dev_RD,
    output logic        Stall,
    output logic        LD_EXP,
    output logic        Bus_Err,
    output logic [31:0] Load_Data_W,
    output logic        Load_Valid_W
);

    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLh  = 6'b100001;
    localparam logic [5:0] OpLhu = 6'b100101;
    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLbu = 6'b100100;

    localparam logic [7:0] TimeoutLast = 8'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dev_data_q, dev_data_d;
    logic        kill_q, kill_d;
    logic        bus_err_q, bus_err_d;
    logic        dm_valid_q;
    logic [5:0]  dm_op_q, dm_op_d;
    logic [1:0]  dm_off_q, dm_off_d;
    logic [31:0] last_q;

    logic [5:0]  opcode;
    logic        is_lw, is_half, is_load;
    logic        in_dm, in_dev, misaligned;
    logic        accept, dm_accept, dev_accept;
    logic [7:0]  dm_byte;
    logic [15:0] dm_half;
    logic [31:0] dm_ext;

    // Only the opcode field matters here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instr_M[25:0];

    // Decode and address check
    always_comb begin
        opcode     = Instr_M[31:26];
        is_lw      = (opcode == OpLw);
        is_half    = (opcode == OpLh) || (opcode == OpLhu);
        is_load    = is_lw || is_half || (opcode == OpLb) || (opcode == OpLbu);
        in_dm      = (ALU_Out_M < DM_LIMIT);
        in_dev     = (ALU_Out_M >= DEV_BASE) && (ALU_Out_M < DEV_LIMIT);
        misaligned = (is_lw && (ALU_Out_M[1:0] != 2'b00)) || (is_half && ALU_Out_M[0]);
        LD_EXP     = is_load && (misaligned || (!in_dm && !in_dev) || (!is_lw && in_dev));
        accept     = is_load && !LD_EXP && !Flush && (state_q == StIdle);
        dm_accept  = accept && in_dm;
        dev_accept = accept && in_dev;
    end

    // Next state
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        dev_data_d = dev_data_q;
        kill_d     = kill_q;
        bus_err_d  = 1'b0;
        dm_op_d    = dm_accept ? opcode : dm_op_q;
        dm_off_d   = dm_accept ? ALU_Out_M[1:0] : dm_off_q;
        case (state_q)
            StIdle: begin
                if (dev_accept) begin
                    state_d = StWait;
                    count_d = 8'd0;
                    kill_d  = 1'b0;
                    addr_d  = {ALU_Out_M[31:2], 2'b00};
                end
            end
            StWait: begin
                // The bus read always completes; a flush only discards its result.
                if (Flush) begin
                    kill_d = 1'b1;
                end
                if (Dev_Ack) begin
                    dev_data_d = Dev_RD;
                    state_d    = StDone;
                end else if (count_q == TimeoutLast) begin
                    dev_data_d = 32'h0;
                    bus_err_d  = 1'b1;
                    state_d    = StDone;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // DM word extraction
    always_comb begin
        dm_byte = DM_RD[{dm_off_q, 3'b000} +: 8];
        dm_half = dm_off_q[1] ? DM_RD[31:16] : DM_RD[15:0];
        case (dm_op_q)
            OpLb:    dm_ext = {{24{dm_byte[7]}}, dm_byte};
            OpLbu:   dm_ext = {24'h0, dm_byte};
            OpLh:    dm_ext = {{16{dm_half[15]}}, dm_half};
            OpLhu:   dm_ext = {16'h0, dm_half};
            default: dm_ext = DM_RD;
        endcase
    end

    // Outputs
    always_comb begin
        Dev_Req      = (state_q == StWait);
        Dev_Addr     = addr_q;
        Stall        = (state_q == StWait) || dev_accept;
        Bus_Err      = bus_err_q;
        Load_Valid_W = dm_valid_q || ((state_q == StDone) && !kill_q);
        if (dm_valid_q) begin
            Load_Data_W = dm_ext;
        end else if ((state_q == StDone) && !kill_q) begin
            Load_Data_W = dev_data_q;
        end else begin
            Load_Data_W = last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= 8'd0;
            addr_q     <= 32'h0;
            dev_data_q <= 32'h0;
            kill_q     <= 1'b0;
            bus_err_q  <= 1'b0;
            dm_valid_q <= 1'b0;
            dm_op_q    <= 6'h0;
            dm_off_q   <= 2'b00;
            last_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            dev_data_q <= dev_data_d;
            kill_q     <= kill_d;
            bus_err_q  <= bus_err_d;
            dm_valid_q <= dm_accept;
            dm_op_q    <= dm_op_d;
            dm_off_q   <= dm_off_d;
            last_q     <= Load_Data_W;
        end
    end

endmodule

// File: tb/tb_load_extender.sv
module tb_load_extender;

    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLh  = 6'b100001;
    localparam logic [5:0] OpLhu = 6'b100101;
    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLbu = 6'b100100;
    localparam logic [5:0] OpAdd = 6'b000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_M, ALU_Out_M, DM_RD, Dev_RD, Dev_Addr, Load_Data_W;
    logic        Flush, Dev_Req, Dev_Ack, Stall, LD_EXP, Bus_Err, Load_Valid_W;

    load_extender dut (
        .clk         (clk),
        .reset       (reset),
        .Instr_M     (Instr_M),
        .ALU_Out_M   (ALU_Out_M),
        .Flush       (Flush),
        .DM_RD       (DM_RD),
        .Dev_Req     (Dev_Req),
        .Dev_Addr    (Dev_Addr),
        .Dev_Ack     (Dev_Ack),
        .Dev_RD      (Dev_RD),
        .Stall       (Stall),
        .LD_EXP      (LD_EXP),
        .Bus_Err     (Bus_Err),
        .Load_Data_W (Load_Data_W),
        .Load_Valid_W(Load_Valid_W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic        flush;
        logic [31:0] dm_rd;
        logic        exp_ex;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] sb[$];
    logic [31:0] last_exp;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop one expected result whenever the DUT presents a valid load.
    task automatic mon();
        logic [31:0] e;
        if (Load_Valid_W === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got data %h expected no valid", Load_Data_W);
            end else begin
                e = sb.pop_front();
                check("load_data", Load_Data_W, e);
                last_exp = e;
            end
        end
    endtask

    task automatic neg();
        @(negedge clk);
        mon();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        Instr_M   = {OpAdd, 26'h0};
        ALU_Out_M = 32'h0;
        Flush     = 1'b0;
    endtask

    // Issue a peripheral lw and follow it to the end of the stall (bounded).
    task automatic dev_run(input logic [31:0] addr, input int ack_at, input int flush_at,
                           input logic [31:0] rd, output int stalls, output int err_at,
                           output int req_bad, output logic valid_seen);
        Instr_M    = {OpLw, 26'h0};
        ALU_Out_M  = addr;
        stalls     = 0;
        err_at     = -1;
        req_bad    = 0;
        valid_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            Dev_Ack = (k == ack_at);
            Dev_RD  = (k == ack_at) ? rd : 32'h5A5A_5A5A;
            Flush   = (k == flush_at);
            @(negedge clk);
            if (Load_Valid_W === 1'b1) valid_seen = 1'b1;
            mon();
            if (Bus_Err === 1'b1) err_at = k;
            if (k == 0 && Dev_Req !== 1'b0) req_bad++;
            if (Stall !== 1'b1) begin
                if (Dev_Req !== 1'b0) req_bad++;
                break;
            end
            if (k > 0 && (Dev_Req !== 1'b1 || Dev_Addr !== {addr[31:2], 2'b00})) req_bad++;
            stalls++;
            pos();
        end
        pos();
        Dev_Ack = 1'b0;
        nop();
    endtask

    int   stalls, err_at, req_bad;
    logic valid_seen;

    initial begin
        vecs[0]  = '{OpLb,  32'h0000_0003, 1'b0, 32'h80FF_1234, 1'b0, 1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{OpLhu, 32'h0000_0002, 1'b0, 32'h8001_5555, 1'b0, 1'b1, 32'h0000_8001};
        vecs[2]  = '{OpLh,  32'h0000_0001, 1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{OpLbu, 32'h0000_0001, 1'b0, 32'h80FF_1234, 1'b0, 1'b1, 32'h0000_0012};
        vecs[4]  = '{OpLb,  32'h0000_0002, 1'b0, 32'h80FF_1234, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[5]  = '{OpLh,  32'h0000_0000, 1'b0, 32'h1234_8765, 1'b0, 1'b1, 32'hFFFF_8765};
        vecs[6]  = '{OpLw,  32'h0000_0100, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[7]  = '{OpLw,  32'h0000_0002, 1'b0, 32'h2222_2222, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{OpLb,  32'h0000_7F00, 1'b0, 32'h3333_3333, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{OpLw,  32'h0000_5000, 1'b0, 32'h4444_4444, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{OpAdd, 32'h0000_0001, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{OpLbu, 32'h0000_2FFF, 1'b0, 32'hAB00_0000, 1'b0, 1'b1, 32'h0000_00AB};
        vecs[12] = '{OpLw,  32'h0000_3000, 1'b0, 32'h6666_6666, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{OpLw,  32'h0000_7F2C, 1'b0, 32'h7777_7777, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{OpLhu, 32'h0000_2FFE, 1'b0, 32'hFFFF_0000, 1'b0, 1'b1, 32'h0000_FFFF};
        vecs[15] = '{OpLw,  32'h0000_2FFC, 1'b1, 32'h8888_8888, 1'b0, 1'b0, 32'h0};

        reset   = 1'b1;
        DM_RD   = 32'h0;
        Dev_Ack = 1'b0;
        Dev_RD  = 32'h0;
        nop();
        pos();
        pos();
        @(negedge clk);
        check("rst_dev_req", {31'h0, Dev_Req}, 32'h0);
        check("rst_stall", {31'h0, Stall}, 32'h0);
        check("rst_bus_err", {31'h0, Bus_Err}, 32'h0);
        check("rst_valid", {31'h0, Load_Valid_W}, 32'h0);
        check("rst_data", Load_Data_W, 32'h0);
        pos();
        reset = 1'b0;

        // Table-driven single-cycle DM loads and exception cases
        for (int i = 0; i < 16; i++) begin
            Instr_M   = {vecs[i].op, 26'h0};
            ALU_Out_M = vecs[i].addr;
            Flush     = vecs[i].flush;
            DM_RD     = 32'hDEAD_0000;
            neg();
            check($sformatf("ld_exp[%0d]", i), {31'h0, LD_EXP}, {31'h0, vecs[i].exp_ex});
            check($sformatf("stall[%0d]", i), {31'h0, Stall}, 32'h0);
            if (vecs[i].exp_valid) sb.push_back(vecs[i].exp_data);
            pos();
            nop();
            DM_RD = vecs[i].dm_rd;
            neg();
            check($sformatf("valid[%0d]", i), {31'h0, Load_Valid_W}, {31'h0, vecs[i].exp_valid});
            pos();
        end

        // Peripheral lw, ack three cycles after issue
        sb.push_back(32'hDEAD_BEEF);
        dev_run(32'h0000_7F04, 3, -1, 32'hDEAD_BEEF, stalls, err_at, req_bad, valid_seen);
        check("ack_stalls", stalls, 4);
        check("ack_req_addr", req_bad, 0);
        check("ack_no_err", err_at, -1);
        check("ack_valid", {31'h0, valid_seen}, 32'h1);

        // No ack: timeout returns zero with a Bus_Err pulse
        sb.push_back(32'h0);
        dev_run(32'h0000_7F08, -1, -1, 32'h0, stalls, err_at, req_bad, valid_seen);
        check("to_stalls", stalls, 16);
        check("to_err_cycle", err_at, 16);
        check("to_req_addr", req_bad, 0);
        check("to_valid", {31'h0, valid_seen}, 32'h1);
        @(negedge clk);
        check("to_err_pulse", {31'h0, Bus_Err}, 32'h0);
        pos();

        // Ack on the timeout cycle wins
        sb.push_back(32'h1234_5678);
        dev_run(32'h0000_7F0C, 15, -1, 32'h1234_5678, stalls, err_at, req_bad, valid_seen);
        check("late_stalls", stalls, 16);
        check("late_no_err", err_at, -1);
        neg();
        check("hold_data", Load_Data_W, last_exp);
        pos();

        // Flush during WAIT: read completes but the result is dropped
        dev_run(32'h0000_7F10, 5, 2, 32'hBAD0_BAD0, stalls, err_at, req_bad, valid_seen);
        check("flush_stalls", stalls, 6);
        check("flush_no_valid", {31'h0, valid_seen}, 32'h0);
        neg();
        check("flush_hold", Load_Data_W, 32'h1234_5678);
        pos();

        // Dev_Ack outside WAIT is ignored
        Dev_Ack = 1'b1;
        Dev_RD  = 32'hFFFF_FFFF;
        neg();
        check("stray_ack_req", {31'h0, Dev_Req}, 32'h0);
        pos();
        Dev_Ack = 1'b0;
        neg();
        check("stray_ack_stall", {31'h0, Stall}, 32'h0);
        pos();

        // Reset in WAIT
        Instr_M   = {OpLw, 26'h0};
        ALU_Out_M = 32'h0000_7F14;
        neg();
        pos();
        neg();
        check("pre_rst_req", {31'h0, Dev_Req}, 32'h1);
        pos();
        reset = 1'b1;
        nop();
        pos();
        reset = 1'b0;
        neg();
        check("wrst_req", {31'h0, Dev_Req}, 32'h0);
        check("wrst_stall", {31'h0, Stall}, 32'h0);
        check("wrst_err", {31'h0, Bus_Err}, 32'h0);
        check("wrst_data", Load_Data_W, 32'h0);
        pos();
        neg();
        check("wrst_err2", {31'h0, Bus_Err}, 32'h0);
        pos();

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
